// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared types and lane helpers for the MEM-stage access engine.
//   mem_size_t      access size encoding (2'b11 behaves as a word)
//   mem_state_t     access FSM states
//   byte_enable     size + address low bits -> little-endian byte lanes
//   replicate_store size + store data -> lane-replicated bus write data
package mem_access_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } mem_state_t;

  // Half accesses only look at a[1]; a[0] is ignored.
  function automatic logic [BE_W-1:0] byte_enable(input logic [1:0] size, input logic [1:0] a);
    logic [BE_W-1:0] be;
    case (size)
      MEM_BYTE: be = BE_W'(4'b0001 << a);
      MEM_HALF: be = a[1] ? 4'b1100 : 4'b0011;
      default:  be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [DATA_W-1:0] replicate_store(input logic [1:0] size,
                                                        input logic [DATA_W-1:0] data);
    logic [DATA_W-1:0] wd;
    case (size)
      MEM_BYTE: wd = {4{data[7:0]}};
      MEM_HALF: wd = {2{data[15:0]}};
      default:  wd = data;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/mem_load_format.sv
// mem_load_format: combinational load formatter.
//   word      raw 32-bit bus read word
//   size      access size (mem_size_t encoding)
//   lane      address bits [1:0] of the access
//   sign_ext  1 = sign-extend byte/half, 0 = zero-extend
//   load_c    formatted 32-bit load value
module mem_load_format
  import mem_access_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        size,
  input  logic [1:0]        lane,
  input  logic              sign_ext,
  output logic [DATA_W-1:0] load_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane, then extend it to the full word.
  always_comb begin
    byte_sel = word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? word[31:16] : word[15:0];
    load_c   = word;
    case (size)
      MEM_BYTE: load_c = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      MEM_HALF: load_c = {{16{sign_ext & half_sel[15]}}, half_sel};
      default:  load_c = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access engine (IDLE -> REQ -> DONE -> IDLE).
// Turns a load/store in EX/MEM into one req/ack word-bus transaction, stalls the
// pipeline until it completes and hands formatted load data to mem_wb in DONE.
//   clk, reset (async, active-low)
//   memReadInput/memWriteInput/memSizeInput/memSignedInput/addressInput/writeDataInput
//                         access request from EX/MEM (held while stalled)
//   stallOutput           pipeline hold (combinational, 1 in IDLE-with-access and REQ)
//   readDataOutput        formatted load data, valid in DONE, held otherwise
//   busErrorOutput        1 in DONE after a timed-out access
//   busReq/Write/Addr/ByteEn/WriteDataOutput, busAckInput, busReadDataInput
//                         word bus master side
// Optional: define MEM_ALIGN_CHECK_EN to add misalignOutput and skip the bus for
// misaligned half/word accesses.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memReadInput,
  input  logic              memWriteInput,
  input  logic [1:0]        memSizeInput,
  input  logic              memSignedInput,
  input  logic [31:0]       addressInput,
  input  logic [31:0]       writeDataInput,
  output logic              stallOutput,
  output logic [31:0]       readDataOutput,
  output logic              busErrorOutput,
  output logic              busReqOutput,
  output logic              busWriteOutput,
  output logic [ADDR_W-1:0] busAddrOutput,
  output logic [3:0]        busByteEnOutput,
  output logic [31:0]       busWriteDataOutput,
  input  logic              busAckInput,
  input  logic [31:0]       busReadDataInput
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic              misalignOutput
`endif
);

  localparam int unsigned WAIT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  mem_state_t        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [1:0]        size_q;
  logic [1:0]        lane_q;
  logic              signed_q;
  logic              access_c;
  logic [31:0]       load_c;

  assign access_c = memReadInput | memWriteInput;

  // Held in reset so the pipeline is released the moment reset asserts.
  assign stallOutput = reset & (((state == ST_IDLE) & access_c) | (state == ST_REQ));

`ifdef MEM_ALIGN_CHECK_EN
  logic misaligned_c;
  assign misaligned_c = ((memSizeInput == MEM_HALF) & addressInput[0]) |
                        (memSizeInput[1] & (addressInput[1:0] != 2'b00));
`endif

  mem_load_format u_load_format (
    .word     (busReadDataInput),
    .size     (size_q),
    .lane     (lane_q),
    .sign_ext (signed_q),
    .load_c   (load_c)
  );

  // Access FSM with registered bus and result outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= ST_IDLE;
      wait_cnt           <= '0;
      size_q             <= 2'b00;
      lane_q             <= 2'b00;
      signed_q           <= 1'b0;
      readDataOutput     <= '0;
      busErrorOutput     <= 1'b0;
      busReqOutput       <= 1'b0;
      busWriteOutput     <= 1'b0;
      busAddrOutput      <= '0;
      busByteEnOutput    <= '0;
      busWriteDataOutput <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      misalignOutput     <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          busErrorOutput <= 1'b0;
          if (access_c) begin
            // Read+write together is treated as a write.
            size_q             <= memSizeInput;
            lane_q             <= addressInput[1:0];
            signed_q           <= memSignedInput;
            wait_cnt           <= '0;
            busWriteOutput     <= memWriteInput;
            busAddrOutput      <= {addressInput[ADDR_W-1:2], 2'b00};
            busByteEnOutput    <= byte_enable(memSizeInput, addressInput[1:0]);
            busWriteDataOutput <= replicate_store(memSizeInput, writeDataInput);
`ifdef MEM_ALIGN_CHECK_EN
            if (misaligned_c) begin
              state          <= ST_DONE;
              readDataOutput <= '0;
              misalignOutput <= 1'b1;
            end else
`endif
            begin
              state        <= ST_REQ;
              busReqOutput <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (busAckInput) begin
            busReqOutput <= 1'b0;
            state        <= ST_DONE;
            if (!busWriteOutput) readDataOutput <= load_c;
          end else if (wait_cnt == WAIT_LAST) begin
            busReqOutput   <= 1'b0;
            state          <= ST_DONE;
            readDataOutput <= '0;
            busErrorOutput <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ST_DONE: begin
          // Same instruction is still on the inputs; do not restart it.
          state          <= ST_IDLE;
          busErrorOutput <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
          misalignOutput <= 1'b0;
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed + randomized bench for mem_access_unit against an
// arithmetic reference model of lane enables, store replication, load extension
// and stall/timeout latency.
module tb_mem_access_unit;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned MAX_WAIT = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        memReadInput, memWriteInput, memSignedInput;
  logic [1:0]  memSizeInput;
  logic [31:0] addressInput, writeDataInput;
  logic        stallOutput, busErrorOutput, busReqOutput, busWriteOutput;
  logic [31:0] readDataOutput, busWriteDataOutput, busReadDataInput;
  logic [ADDR_W-1:0] busAddrOutput;
  logic [3:0]  busByteEnOutput;
  logic        busAckInput;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misalignOutput;
`endif

  int checks   = 0;
  int failures = 0;

  mem_access_unit #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk                (clk),
    .reset              (reset),
    .memReadInput       (memReadInput),
    .memWriteInput      (memWriteInput),
    .memSizeInput       (memSizeInput),
    .memSignedInput     (memSignedInput),
    .addressInput       (addressInput),
    .writeDataInput     (writeDataInput),
    .stallOutput        (stallOutput),
    .readDataOutput     (readDataOutput),
    .busErrorOutput     (busErrorOutput),
    .busReqOutput       (busReqOutput),
    .busWriteOutput     (busWriteOutput),
    .busAddrOutput      (busAddrOutput),
    .busByteEnOutput    (busByteEnOutput),
    .busWriteDataOutput (busWriteDataOutput),
    .busAckInput        (busAckInput),
    .busReadDataInput   (busReadDataInput)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .misalignOutput     (misalignOutput)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
    int unsigned off;
    off = a % 4;
    if (sz == 2'd0) return 4'(1 << off);
    if (sz == 2'd1) return 4'(3 << (2 * (off / 2)));
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wd(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] model_ld(input logic [1:0] sz, input logic sg,
                                           input logic [31:0] a, input logic [31:0] rw);
    int unsigned off, sh;
    logic [31:0] mask, v;
    off = a % 4;
    if (sz == 2'd0) begin sh = off * 8;         mask = 32'hFF;   end
    else if (sz == 2'd1) begin sh = (off / 2) * 16; mask = 32'hFFFF; end
    else return rw;
    v = (rw >> sh) & mask;
    if (sg && ((v & ((mask + 1) >> 1)) != 0)) v = v | ~mask;
    return v;
  endfunction

  function automatic bit model_misaligned(input logic [1:0] sz, input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
    if (sz == 2'd1) return a[0];
    if (sz >= 2'd2) return (a % 4) != 0;
`endif
    return 1'b0;
  endfunction

  // One instruction in MEM; ack_wait<0 withholds ack. Called at posedge+1 in IDLE.
  task automatic do_access(input bit rd, input bit wr, input logic [1:0] sz, input bit sg,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rw, input int ack_wait);
    int  stalls, reqs, exp_stalls, exp_reqs;
    bit  done, is_mem, is_mis, tmo;
    memReadInput = rd; memWriteInput = wr; memSizeInput = sz; memSignedInput = sg;
    addressInput = a; writeDataInput = wd; busReadDataInput = rw; busAckInput = 1'b0;
    is_mem = rd | wr;
    is_mis = is_mem && model_misaligned(sz, a);
    tmo    = is_mem && !is_mis && (ack_wait < 0 || ack_wait >= int'(MAX_WAIT));
    stalls = 0; reqs = 0; done = 1'b0;
    while (!done && stalls < 64) begin
      @(negedge clk);
      if (!stallOutput) done = 1'b1;
      else begin
        stalls++;
        if (busReqOutput) begin
          if (reqs == 0) begin
            check_val("bus_addr", busAddrOutput, a & 32'hFFFF_FFFC);
            check_val("bus_be", 32'(busByteEnOutput), 32'(model_be(sz, a)));
            check_val("bus_write", 32'(busWriteOutput), 32'(wr));
            if (wr) check_val("bus_wdata", busWriteDataOutput, model_wd(sz, wd));
          end
          busAckInput = (ack_wait >= 0) && (reqs == ack_wait);
          reqs++;
        end
        @(posedge clk); #1;
        busAckInput = 1'b0;
      end
    end
    check_val("done_bound", 32'(done), 32'd1);
    if (!is_mem)     begin exp_stalls = 0;                 exp_reqs = 0; end
    else if (is_mis) begin exp_stalls = 1;                 exp_reqs = 0; end
    else if (tmo)    begin exp_stalls = 1 + int'(MAX_WAIT); exp_reqs = int'(MAX_WAIT); end
    else             begin exp_stalls = 2 + ack_wait;      exp_reqs = ack_wait + 1; end
    check_val("stall_cycles", 32'(stalls), 32'(exp_stalls));
    check_val("req_cycles", 32'(reqs), 32'(exp_reqs));
    check_val("req_low_done", 32'(busReqOutput), 32'd0);
    if (is_mem) begin
      check_val("bus_error", 32'(busErrorOutput), 32'(tmo));
      if (is_mis || tmo) check_val("rdata_zero", readDataOutput, 32'd0);
      else if (rd && !wr) check_val("rdata", readDataOutput, model_ld(sz, sg, a, rw));
`ifdef MEM_ALIGN_CHECK_EN
      check_val("misalign", 32'(misalignOutput), 32'(is_mis));
`endif
    end
    @(posedge clk); #1;
    memReadInput = 1'b0; memWriteInput = 1'b0;
    if (is_mem) check_val("error_pulse_end", 32'(busErrorOutput), 32'd0);
  endtask

  initial begin
    int r, aw;
    reset = 1'b0;
    memReadInput = 1'b0; memWriteInput = 1'b0; memSizeInput = 2'b00; memSignedInput = 1'b0;
    addressInput = '0; writeDataInput = '0; busAckInput = 1'b0; busReadDataInput = '0;
    #3;
    check_val("rst_stall", 32'(stallOutput), 32'd0);
    check_val("rst_req", 32'(busReqOutput), 32'd0);
    check_val("rst_rdata", readDataOutput, 32'd0);
    check_val("rst_err", 32'(busErrorOutput), 32'd0);
    check_val("rst_addr", busAddrOutput, 32'd0);
    check_val("rst_be", 32'(busByteEnOutput), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    do_access(1, 0, 2'b10, 0, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
    do_access(1, 0, 2'b00, 1, 32'h103, 32'h0, 32'h80FF_FF7F, 0);
    check_val("lb_signed", readDataOutput, 32'hFFFF_FF80);
    do_access(1, 0, 2'b00, 0, 32'h103, 32'h0, 32'h80FF_FF7F, 2);
    check_val("lbu", readDataOutput, 32'h0000_0080);
    do_access(0, 1, 2'b01, 0, 32'h102, 32'h1234_ABCD, 32'h0, 1);
    do_access(0, 0, 2'b10, 0, 32'h104, 32'h0, 32'h0, 0);
    do_access(1, 0, 2'b10, 0, 32'h108, 32'h0, 32'h1111_2222, -1);
    do_access(1, 1, 2'b11, 1, 32'h10C, 32'h5555_AAAA, 32'h0, 3);
    do_access(1, 0, 2'b10, 0, 32'h102, 32'h0, 32'hCAFE_F00D, 0);

    // Reset asserted mid-REQ after three unacked cycles
    memReadInput = 1'b1; memSizeInput = 2'b10; addressInput = 32'h200;
    repeat (4) @(posedge clk);
    #2;
    check_val("pre_rst_req", 32'(busReqOutput), 32'd1);
    reset = 1'b0;
    #1;
    check_val("async_rst_req", 32'(busReqOutput), 32'd0);
    check_val("async_rst_stall", 32'(stallOutput), 32'd0);
    memReadInput = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("no_replay_req", 32'(busReqOutput), 32'd0);
      check_val("no_replay_stall", 32'(stallOutput), 32'd0);
    end
    @(posedge clk); #1;

    // Randomized instruction stream
    for (int n = 0; n < 80; n++) begin
      r  = $urandom_range(0, 9);
      aw = (r == 0) ? -1 : int'($urandom_range(0, 4));
      case ($urandom_range(0, 4))
        0:       do_access(0, 0, 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom, aw);
        1, 2:    do_access(1, 0, 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom, aw);
        3:       do_access(0, 1, 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom, aw);
        default: do_access(1, 1, 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom, aw);
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
